age_ordered_rs: RTL and testbench
=================================

AGE_ORDERED_RS -- requirements
Module: age_ordered_rs

Interface
REQ-001 Parameter PREG_WIDTH, default 7: physical register tag width.
REQ-002 Parameter ROB_WIDTH, default 4: ROB tag width.
REQ-003 Parameter RS_SIZE, default 8: entry count, 2..32.
REQ-004 Parameter NUM_CDB, default 2: wakeup broadcast ports, 1..4.
REQ-005 Parameter PAYLOAD_W, default 70: opaque payload width (pc, imm, alu_op, alusrc, memwrite).
REQ-006 clk  in  1  clock, all state on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 i_valid  in  1  allocation request.
REQ-009 i_prs1, i_prs2, i_prd  in  PREG_WIDTH each  source and destination tags.
REQ-010 i_rob_tag  in  ROB_WIDTH  ROB tag of the incoming instruction.
REQ-011 i_payload  in  PAYLOAD_W  carried unmodified to issue.
REQ-012 i_rs1_ready, i_rs2_ready  in  1 each  initial operand readiness.
REQ-013 o_full  out  1  no free entry; o_count  out  $clog2(RS_SIZE+1)  valid entries.
REQ-014 i_cdb_valid  in  NUM_CDB, and i_cdb_prd  in  NUM_CDB*PREG_WIDTH  wakeup ports, port k in bits [k*PREG_WIDTH +: PREG_WIDTH].
REQ-015 i_rob_head  in  ROB_WIDTH  tag of the oldest in-flight instruction.
REQ-016 i_eu_ready  in  1; o_issue_valid  out  1; o_issue_prs1/prs2/prd  out  PREG_WIDTH; o_issue_rob_tag  out  ROB_WIDTH; o_issue_payload  out  PAYLOAD_W.
REQ-017 branch_mispredict  in  1; branch_rob_tag  in  ROB_WIDTH  tag of the mispredicting branch.

Function
REQ-018 Age of a tag SHALL be (tag - i_rob_head) mod 2^ROB_WIDTH; smaller age is older.
REQ-019 o_issue_valid SHALL be combinationally high when any valid entry has both operands ready.
REQ-020 Issue select SHALL pick the ready entry with the smallest age; on an age tie, the lowest index wins.
REQ-021 When o_issue_valid is low, all o_issue_* data outputs SHALL be zero.
REQ-022 Issue SHALL fire when o_issue_valid && i_eu_ready; the selected entry SHALL be freed at that edge.
REQ-023 Allocation SHALL fire when i_valid && !o_full && !branch_mispredict, into the lowest-index free entry as seen before the edge.
REQ-024 When i_valid && o_full, the request SHALL be dropped with no state change.
REQ-025 Allocated operand readiness SHALL be i_rsX_ready OR a same-cycle match on any valid CDB port.
REQ-026 Each cycle, every valid entry SHALL set rsX_ready when any valid CDB port carries prsX.
REQ-027 Tag 0 SHALL never match a CDB wakeup.
REQ-028 Wakeup SHALL only make an operand ready from the next cycle; there is no same-cycle issue bypass.
REQ-029 On branch_mispredict, every valid entry whose age is greater than age(branch_rob_tag) SHALL be invalidated at that edge; the branch itself and older entries SHALL be kept.
REQ-030 When issue and flush target the same entry in one cycle, the entry SHALL be invalidated and the issue handshake SHALL still complete (the EU discards it via ROB).
REQ-031 o_count SHALL equal the number of valid entries after each edge; o_full = (o_count == RS_SIZE).
REQ-032 Simultaneous allocation and issue while full SHALL NOT allocate.
REQ-033 ROB tag wrap-around SHALL be handled solely by the modular age of REQ-018.

Reset
REQ-034 While reset is high, all entries SHALL become invalid with ready bits cleared, o_count = 0, o_full = 0, o_issue_valid = 0 and issue data = 0.
REQ-035 Reset SHALL override allocation, wakeup, issue and flush in the same cycle.

Structure
REQ-036 Package rs_pkg SHALL hold the rs_entry_t struct (valid, rs1_ready, rs2_ready, prs1, prs2, prd, rob_tag, payload) and the rob_age function.
REQ-037 Oldest-ready selection SHALL be a sub-module rs_age_select (inputs: ready vector and ages; outputs: one-hot grant and found).

Verification
REQ-038 Age order: head=14; allocate tags 15, 0, 1 all ready; eu_ready=1 -> issue order 15, 0, 1.
REQ-039 Dual CDB: entry waits on prs1=5 and prs2=9; CDB0=5 and CDB1=9 in the same cycle -> o_issue_valid=1 next cycle.
REQ-040 Flush: head=0; entries with tags 2, 3, 5; mispredict tag=3 -> only tag 2 and tag 3 remain, o_count=2.
REQ-041 Full: 8 allocations -> o_full=1; 9th dropped; issue one -> next allocation lands in the freed index.
REQ-042 Allocate-wakeup race: allocate prs1=7 not ready while CDB1=7 -> entry ready; prd=0 broadcast wakes nothing.
REQ-043 Reset mid-operation with 5 valid entries -> o_count=0 and o_issue_valid=0 the next cycle.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared types and helpers for the age-ordered reservation station.
// Struct fields are sized to the largest supported widths and zero-extended.
package rs_pkg;

    localparam int MAX_PREG    = 16;
    localparam int MAX_ROB     = 16;
    localparam int MAX_PAYLOAD = 128;

    typedef logic [MAX_PREG-1:0]    preg_t;
    typedef logic [MAX_ROB-1:0]     rob_t;
    typedef logic [MAX_PAYLOAD-1:0] payload_t;

    typedef struct packed {
        logic     valid;
        logic     rs1_ready;
        logic     rs2_ready;
        preg_t    prs1;
        preg_t    prs2;
        preg_t    prd;
        rob_t     rob_tag;
        payload_t payload;
    } rs_entry_t;

    // Distance from the ROB head, modulo 2^w; wrap-around falls out of this.
    function automatic rob_t rob_age(rob_t tag, rob_t head, int unsigned w);
        rob_t mask;
        mask = rob_t'((64'd1 << w) - 64'd1);
        return (tag - head) & mask;
    endfunction

endpackage

// File: rtl/rs_age_select.sv
// Oldest-ready picker: grants the ready slot with the smallest age.
// Ports: ready vector, flattened ages in; one-hot grant and found out.
module rs_age_select #(
    parameter int N  = 8,
    parameter int AW = 16
) (
    input  logic [N-1:0]    ready,
    input  logic [N*AW-1:0] ages,
    output logic [N-1:0]    grant,
    output logic            found
);

    logic [AW-1:0] best;

    // Strict less-than keeps the lowest index on an age tie.
    always_comb begin
        grant = '0;
        found = 1'b0;
        best  = '0;
        for (int i = 0; i < N; i++) begin
            if (ready[i] && (!found || ages[i*AW +: AW] < best)) begin
                grant    = '0;
                grant[i] = 1'b1;
                found    = 1'b1;
                best     = ages[i*AW +: AW];
            end
        end
    end

endmodule

// File: rtl/age_ordered_rs.sv
// Age-ordered reservation station: allocate, CDB wakeup, oldest-first issue, flush.
// Ports: alloc (i_*), o_full/o_count, CDB wakeup, rob head, issue handshake, mispredict.
module age_ordered_rs
    import rs_pkg::*;
#(
    parameter int PREG_WIDTH = 7,
    parameter int ROB_WIDTH  = 4,
    parameter int RS_SIZE    = 8,
    parameter int NUM_CDB    = 2,
    parameter int PAYLOAD_W  = 70,
    localparam int CW = $clog2(RS_SIZE + 1),
    localparam int IW = $clog2(RS_SIZE)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_valid,
    input  logic [PREG_WIDTH-1:0]         i_prs1,
    input  logic [PREG_WIDTH-1:0]         i_prs2,
    input  logic [PREG_WIDTH-1:0]         i_prd,
    input  logic [ROB_WIDTH-1:0]          i_rob_tag,
    input  logic [PAYLOAD_W-1:0]          i_payload,
    input  logic                          i_rs1_ready,
    input  logic                          i_rs2_ready,
    output logic                          o_full,
    output logic [CW-1:0]                 o_count,
    input  logic [NUM_CDB-1:0]            i_cdb_valid,
    input  logic [NUM_CDB*PREG_WIDTH-1:0] i_cdb_prd,
    input  logic [ROB_WIDTH-1:0]          i_rob_head,
    input  logic                          i_eu_ready,
    output logic                          o_issue_valid,
    output logic [PREG_WIDTH-1:0]         o_issue_prs1,
    output logic [PREG_WIDTH-1:0]         o_issue_prs2,
    output logic [PREG_WIDTH-1:0]         o_issue_prd,
    output logic [ROB_WIDTH-1:0]          o_issue_rob_tag,
    output logic [PAYLOAD_W-1:0]          o_issue_payload,
    input  logic                          branch_mispredict,
    input  logic [ROB_WIDTH-1:0]          branch_rob_tag
);

    rs_entry_t ent   [RS_SIZE];
    rs_entry_t ent_n [RS_SIZE];

    rob_t                   age [RS_SIZE];
    logic [RS_SIZE*MAX_ROB-1:0] ages_flat;
    logic [RS_SIZE-1:0]     ready_vec;
    logic [RS_SIZE-1:0]     grant;
    logic                   found;
    logic [CW-1:0]          count;
    logic [IW-1:0]          free_idx;
    rob_t                   head;
    rob_t                   bage;
    rs_entry_t              iss;
    logic                   issue_fire;
    logic                   alloc_fire;

    // Tag 0 is the hardwired zero register and is never woken.
    function automatic logic cdb_hit(preg_t tag);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (i_cdb_valid[k] && tag != '0 &&
                preg_t'(i_cdb_prd[k*PREG_WIDTH +: PREG_WIDTH]) == tag)
                hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        head      = rob_t'(i_rob_head);
        bage      = rob_age(rob_t'(branch_rob_tag), head, ROB_WIDTH);
        ages_flat = '0;
        ready_vec = '0;
        count     = '0;
        free_idx  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            age[i] = rob_age(ent[i].rob_tag, head, ROB_WIDTH);
            ages_flat[i*MAX_ROB +: MAX_ROB] = age[i];
            ready_vec[i] = ent[i].valid & ent[i].rs1_ready & ent[i].rs2_ready;
            count = count + CW'(ent[i].valid);
        end
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!ent[i].valid)
                free_idx = IW'(i);
        end
    end

    rs_age_select #(
        .N  (RS_SIZE),
        .AW (MAX_ROB)
    ) u_sel (
        .ready (ready_vec),
        .ages  (ages_flat),
        .grant (grant),
        .found (found)
    );

    assign o_count    = count;
    assign o_full     = (count == CW'(RS_SIZE));
    assign issue_fire = found && i_eu_ready;
    assign alloc_fire = i_valid && !o_full && !branch_mispredict;

    always_comb begin
        iss = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (grant[i])
                iss = ent[i];
        end
    end

    assign o_issue_valid   = found;
    assign o_issue_prs1    = iss.prs1[PREG_WIDTH-1:0];
    assign o_issue_prs2    = iss.prs2[PREG_WIDTH-1:0];
    assign o_issue_prd     = iss.prd[PREG_WIDTH-1:0];
    assign o_issue_rob_tag = iss.rob_tag[ROB_WIDTH-1:0];
    assign o_issue_payload = iss.payload[PAYLOAD_W-1:0];

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ent_n[i] = ent[i];
            if (ent[i].valid) begin
                if (cdb_hit(ent[i].prs1))
                    ent_n[i].rs1_ready = 1'b1;
                if (cdb_hit(ent[i].prs2))
                    ent_n[i].rs2_ready = 1'b1;
                if (issue_fire && grant[i])
                    ent_n[i].valid = 1'b0;
                if (branch_mispredict && age[i] > bage)
                    ent_n[i].valid = 1'b0;
            end
            // Free slot is never a flush or issue target, so no conflict.
            if (alloc_fire && free_idx == IW'(i)) begin
                ent_n[i]           = '0;
                ent_n[i].valid     = 1'b1;
                ent_n[i].prs1      = preg_t'(i_prs1);
                ent_n[i].prs2      = preg_t'(i_prs2);
                ent_n[i].prd       = preg_t'(i_prd);
                ent_n[i].rob_tag   = rob_t'(i_rob_tag);
                ent_n[i].payload   = payload_t'(i_payload);
                ent_n[i].rs1_ready = i_rs1_ready | cdb_hit(preg_t'(i_prs1));
                ent_n[i].rs2_ready = i_rs2_ready | cdb_hit(preg_t'(i_prs2));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RS_SIZE; i++)
                ent[i] <= '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++)
                ent[i] <= ent_n[i];
        end
    end

endmodule

// File: tb/tb_age_ordered_rs.sv
// Scoreboard bench for age_ordered_rs: expected issues queued at allocation,
// popped and compared when the station presents them.
module tb_age_ordered_rs;

    logic        clk;
    logic        reset;
    logic        i_valid;
    logic [6:0]  i_prs1, i_prs2, i_prd;
    logic [3:0]  i_rob_tag;
    logic [69:0] i_payload;
    logic        i_rs1_ready, i_rs2_ready;
    logic        o_full;
    logic [3:0]  o_count;
    logic [1:0]  i_cdb_valid;
    logic [13:0] i_cdb_prd;
    logic [3:0]  i_rob_head;
    logic        i_eu_ready;
    logic        o_issue_valid;
    logic [6:0]  o_issue_prs1, o_issue_prs2, o_issue_prd;
    logic [3:0]  o_issue_rob_tag;
    logic [69:0] o_issue_payload;
    logic        branch_mispredict;
    logic [3:0]  branch_rob_tag;

    typedef struct {
        logic [3:0]  tag;
        logic [6:0]  prd;
        logic [69:0] pl;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    age_ordered_rs dut (
        .clk               (clk),
        .reset             (reset),
        .i_valid           (i_valid),
        .i_prs1            (i_prs1),
        .i_prs2            (i_prs2),
        .i_prd             (i_prd),
        .i_rob_tag         (i_rob_tag),
        .i_payload         (i_payload),
        .i_rs1_ready       (i_rs1_ready),
        .i_rs2_ready       (i_rs2_ready),
        .o_full            (o_full),
        .o_count           (o_count),
        .i_cdb_valid       (i_cdb_valid),
        .i_cdb_prd         (i_cdb_prd),
        .i_rob_head        (i_rob_head),
        .i_eu_ready        (i_eu_ready),
        .o_issue_valid     (o_issue_valid),
        .o_issue_prs1      (o_issue_prs1),
        .o_issue_prs2      (o_issue_prs2),
        .o_issue_prd       (o_issue_prd),
        .o_issue_rob_tag   (o_issue_rob_tag),
        .o_issue_payload   (o_issue_payload),
        .branch_mispredict (branch_mispredict),
        .branch_rob_tag    (branch_rob_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [6:0] p1, input logic [6:0] p2,
                         input logic [6:0] pd, input logic [3:0] tag,
                         input logic r1, input logic r2,
                         input logic [69:0] pl);
        i_valid     = 1'b1;
        i_prs1      = p1;
        i_prs2      = p2;
        i_prd       = pd;
        i_rob_tag   = tag;
        i_rs1_ready = r1;
        i_rs2_ready = r2;
        i_payload   = pl;
        cyc();
        i_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [3:0] tag, input logic [6:0] pd,
                            input logic [69:0] pl);
        exp_t e;
        e.tag = tag;
        e.prd = pd;
        e.pl  = pl;
        q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        checks++;
        if (o_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", o_count);
        end
        checks++;
        if (o_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_full: got %b want 0", o_full);
        end
        checks++;
        if (o_issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_issue_valid: got %b want 0", o_issue_valid);
        end
        checks++;
        if (o_issue_payload !== '0 || o_issue_rob_tag !== '0 ||
            o_issue_prd !== '0) begin
            errors++;
            $display("FAIL reset_issue_data: tag=%0d prd=%0d want zeros",
                     o_issue_rob_tag, o_issue_prd);
        end
    endtask

    task automatic test_age_order();
        logic [3:0]  tg [3];
        logic [69:0] pl [3];
        exp_t e;
        tg[0] = 4'd1;
        tg[1] = 4'd0;
        tg[2] = 4'd15;
        i_rob_head = 4'd14;
        for (int i = 0; i < 3; i++) begin
            pl[i] = {$urandom, $urandom, 6'(i)};
            alloc(7'd1, 7'd2, 7'(20 + i), tg[i], 1'b1, 1'b1, pl[i]);
        end
        for (int i = 2; i >= 0; i--)
            push_exp(tg[i], 7'(20 + i), pl[i]);
        #1;
        checks++;
        if (o_count !== 4'd3) begin
            errors++;
            $display("FAIL age_count: got %0d want 3", o_count);
        end
        for (int k = 0; k < 3; k++) begin
            i_eu_ready = 1'b1;
            #1;
            e = q.pop_front();
            checks++;
            if (o_issue_valid !== 1'b1 || o_issue_rob_tag !== e.tag ||
                o_issue_prd !== e.prd || o_issue_payload !== e.pl) begin
                errors++;
                $display("FAIL age_issue[%0d]: valid=%b tag=%0d prd=%0d want tag=%0d prd=%0d",
                         k, o_issue_valid, o_issue_rob_tag, o_issue_prd, e.tag, e.prd);
            end
            cyc();
        end
        i_eu_ready = 1'b0;
        #1;
        checks++;
        if (o_count !== 4'd0 || o_issue_valid !== 1'b0 ||
            o_issue_rob_tag !== 4'd0) begin
            errors++;
            $display("FAIL age_drain: count=%0d valid=%b tag=%0d want 0/0/0",
                     o_count, o_issue_valid, o_issue_rob_tag);
        end
    endtask

    task automatic test_dual_cdb();
        logic [69:0] pl;
        exp_t e;
        i_rob_head = 4'd0;
        pl = {$urandom, $urandom, 6'd33};
        alloc(7'd5, 7'd9, 7'd30, 4'd3, 1'b0, 1'b0, pl);
        push_exp(4'd3, 7'd30, pl);
        #1;
        checks++;
        if (o_issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL cdb_wait: valid=%b want 0", o_issue_valid);
        end
        i_cdb_valid = 2'b11;
        i_cdb_prd   = {7'd9, 7'd5};
        #1;
        checks++;
        if (o_issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL cdb_no_bypass: valid=%b want 0", o_issue_valid);
        end
        cyc();
        i_cdb_valid = 2'b00;
        #1;
        e = q.pop_front();
        checks++;
        if (o_issue_valid !== 1'b1 || o_issue_rob_tag !== e.tag ||
            o_issue_prs1 !== 7'd5 || o_issue_prs2 !== 7'd9 ||
            o_issue_payload !== e.pl) begin
            errors++;
            $display("FAIL cdb_wake: valid=%b tag=%0d prs1=%0d prs2=%0d want 1/%0d/5/9",
                     o_issue_valid, o_issue_rob_tag, o_issue_prs1, o_issue_prs2, e.tag);
        end
        i_eu_ready = 1'b1;
        cyc();
        i_eu_ready = 1'b0;
        #1;
        checks++;
        if (o_count !== 4'd0) begin
            errors++;
            $display("FAIL cdb_drain: count=%0d want 0", o_count);
        end
    endtask

    task automatic test_flush();
        logic [69:0] pl [3];
        exp_t e;
        i_rob_head = 4'd0;
        for (int i = 0; i < 3; i++)
            pl[i] = {$urandom, $urandom, 6'(40 + i)};
        alloc(7'd10, 7'd1, 7'd40, 4'd2, 1'b0, 1'b1, pl[0]);
        alloc(7'd11, 7'd1, 7'd41, 4'd3, 1'b0, 1'b1, pl[1]);
        alloc(7'd12, 7'd1, 7'd42, 4'd5, 1'b0, 1'b1, pl[2]);
        i_cdb_valid = 2'b01;
        i_cdb_prd   = {7'd0, 7'd12};
        cyc();
        i_cdb_valid = 2'b00;
        branch_mispredict = 1'b1;
        branch_rob_tag    = 4'd3;
        i_eu_ready        = 1'b1;
        i_valid           = 1'b1;
        i_prs1            = 7'd1;
        i_prs2            = 7'd1;
        i_prd             = 7'd43;
        i_rob_tag         = 4'd6;
        i_rs1_ready       = 1'b1;
        i_rs2_ready       = 1'b1;
        #1;
        checks++;
        if (o_issue_valid !== 1'b1 || o_issue_rob_tag !== 4'd5) begin
            errors++;
            $display("FAIL flush_issue_same: valid=%b tag=%0d want 1/5",
                     o_issue_valid, o_issue_rob_tag);
        end
        cyc();
        branch_mispredict = 1'b0;
        i_eu_ready        = 1'b0;
        i_valid           = 1'b0;
        #1;
        checks++;
        if (o_count !== 4'd2 || o_issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_count: count=%0d valid=%b want 2/0",
                     o_count, o_issue_valid);
        end
        i_cdb_valid = 2'b11;
        i_cdb_prd   = {7'd11, 7'd10};
        cyc();
        i_cdb_valid = 2'b00;
        push_exp(4'd2, 7'd40, pl[0]);
        push_exp(4'd3, 7'd41, pl[1]);
        for (int k = 0; k < 2; k++) begin
            i_eu_ready = 1'b1;
            #1;
            e = q.pop_front();
            checks++;
            if (o_issue_valid !== 1'b1 || o_issue_rob_tag !== e.tag ||
                o_issue_prd !== e.prd || o_issue_payload !== e.pl) begin
                errors++;
                $display("FAIL flush_survivor[%0d]: valid=%b tag=%0d want tag=%0d",
                         k, o_issue_valid, o_issue_rob_tag, e.tag);
            end
            cyc();
        end
        i_eu_ready = 1'b0;
        #1;
        checks++;
        if (o_count !== 4'd0 || o_issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drain: count=%0d valid=%b want 0/0",
                     o_count, o_issue_valid);
        end
    endtask

    task automatic test_full();
        logic [69:0] pl [8];
        logic [69:0] pln;
        exp_t e;
        i_rob_head = 4'd0;
        for (int i = 0; i < 8; i++) begin
            pl[i] = {$urandom, $urandom, 6'(i)};
            alloc(7'(30 + i), 7'd1, 7'(50 + i), 4'(i), 1'b0, 1'b1, pl[i]);
        end
        #1;
        checks++;
        if (o_full !== 1'b1 || o_count !== 4'd8) begin
            errors++;
            $display("FAIL full_flag: full=%b count=%0d want 1/8", o_full, o_count);
        end
        alloc(7'd1, 7'd1, 7'd60, 4'd8, 1'b1, 1'b1, {$urandom, $urandom, 6'd8});
        #1;
        checks++;
        if (o_count !== 4'd8 || o_issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_drop: count=%0d valid=%b want 8/0",
                     o_count, o_issue_valid);
        end
        i_cdb_valid = 2'b01;
        i_cdb_prd   = {7'd0, 7'd33};
        cyc();
        i_cdb_valid = 2'b00;
        i_valid     = 1'b1;
        i_prs1      = 7'd1;
        i_prs2      = 7'd1;
        i_prd       = 7'd62;
        i_rob_tag   = 4'd9;
        i_rs1_ready = 1'b1;
        i_rs2_ready = 1'b1;
        i_eu_ready  = 1'b1;
        #1;
        checks++;
        if (o_issue_valid !== 1'b1 || o_issue_rob_tag !== 4'd3 ||
            o_issue_payload !== pl[3]) begin
            errors++;
            $display("FAIL full_issue: valid=%b tag=%0d want 1/3",
                     o_issue_valid, o_issue_rob_tag);
        end
        cyc();
        i_valid    = 1'b0;
        i_eu_ready = 1'b0;
        #1;
        checks++;
        if (o_count !== 4'd7 || o_full !== 1'b0 || o_issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_no_alloc_on_issue: count=%0d full=%b valid=%b want 7/0/0",
                     o_count, o_full, o_issue_valid);
        end
        pln = {$urandom, $urandom, 6'd61};
        alloc(7'd1, 7'd1, 7'd61, 4'd5, 1'b1, 1'b1, pln);
        i_cdb_valid = 2'b01;
        i_cdb_prd   = {7'd0, 7'd35};
        cyc();
        i_cdb_valid = 2'b00;
        push_exp(4'd5, 7'd61, pln);
        push_exp(4'd5, 7'd55, pl[5]);
        for (int k = 0; k < 2; k++) begin
            i_eu_ready = 1'b1;
            #1;
            e = q.pop_front();
            checks++;
            if (o_issue_valid !== 1'b1 || o_issue_prd !== e.prd ||
                o_issue_payload !== e.pl) begin
                errors++;
                $display("FAIL full_reuse_tie[%0d]: valid=%b prd=%0d want prd=%0d",
                         k, o_issue_valid, o_issue_prd, e.prd);
            end
            cyc();
        end
        i_eu_ready = 1'b0;
        do_reset();
    endtask

    task automatic test_race();
        logic [69:0] pl;
        exp_t e;
        i_rob_head = 4'd0;
        alloc(7'd0, 7'd1, 7'd70, 4'd1, 1'b0, 1'b1, {$urandom, $urandom, 6'd1});
        pl          = {$urandom, $urandom, 6'd2};
        i_cdb_valid = 2'b11;
        i_cdb_prd   = {7'd7, 7'd0};
        alloc(7'd7, 7'd1, 7'd71, 4'd2, 1'b0, 1'b1, pl);
        i_cdb_valid = 2'b00;
        push_exp(4'd2, 7'd71, pl);
        #1;
        e = q.pop_front();
        checks++;
        if (o_issue_valid !== 1'b1 || o_issue_rob_tag !== e.tag ||
            o_issue_prd !== e.prd || o_issue_payload !== e.pl) begin
            errors++;
            $display("FAIL race_wake: valid=%b tag=%0d want 1/%0d",
                     o_issue_valid, o_issue_rob_tag, e.tag);
        end
        i_eu_ready = 1'b1;
        cyc();
        i_eu_ready = 1'b0;
        #1;
        checks++;
        if (o_issue_valid !== 1'b0 || o_count !== 4'd1) begin
            errors++;
            $display("FAIL race_tag0: valid=%b count=%0d want 0/1",
                     o_issue_valid, o_count);
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        i_rob_head = 4'd0;
        for (int i = 0; i < 5; i++)
            alloc(7'd1, 7'd1, 7'(80 + i), 4'(i), 1'b1, 1'b1,
                  {$urandom, $urandom, 6'(i)});
        #1;
        checks++;
        if (o_count !== 4'd5 || o_issue_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: count=%0d valid=%b want 5/1",
                     o_count, o_issue_valid);
        end
        reset       = 1'b1;
        i_valid     = 1'b1;
        i_eu_ready  = 1'b1;
        i_cdb_valid = 2'b11;
        cyc();
        checks++;
        if (o_count !== 4'd0 || o_issue_valid !== 1'b0 ||
            o_issue_payload !== '0) begin
            errors++;
            $display("FAIL mid_reset: count=%0d valid=%b want 0/0",
                     o_count, o_issue_valid);
        end
        reset       = 1'b0;
        i_valid     = 1'b0;
        i_eu_ready  = 1'b0;
        i_cdb_valid = 2'b00;
        #1;
        checks++;
        if (o_count !== 4'd0 || o_full !== 1'b0) begin
            errors++;
            $display("FAIL mid_after: count=%0d full=%b want 0/0", o_count, o_full);
        end
    endtask

    initial begin
        reset             = 1'b1;
        i_valid           = 1'b0;
        i_prs1            = '0;
        i_prs2            = '0;
        i_prd             = '0;
        i_rob_tag         = '0;
        i_payload         = '0;
        i_rs1_ready       = 1'b0;
        i_rs2_ready       = 1'b0;
        i_cdb_valid       = '0;
        i_cdb_prd         = '0;
        i_rob_head        = '0;
        i_eu_ready        = 1'b0;
        branch_mispredict = 1'b0;
        branch_rob_tag    = '0;
        test_reset();
        test_age_order();
        test_dual_cdb();
        test_flush();
        test_full();
        test_race();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
